pipe_addsub_n: RTL
==================

// Module: pipe_addsub_n
// PURPOSE
//  Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake.
//  Splits the carry chain into STAGES equal slices with one register per slice,
//  so wide adds close timing. Operands are skewed into the pipe, and results are
//  de-skewed to emerge aligned. Replaces the fixed 4-bit ripple adder wherever
//  the datapath is registered.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; WIDTH % STAGES must be 0
//  STAGES  4  pipeline depth = slice count; slice width W_S = WIDTH/STAGES; >= 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin   1: a-b-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      raw carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (async assert; release sampled on clk): all stage valid bits = 0,
//    all data registers = 0. Outputs sum/cout/ovf = 0, zero = 1, out_valid = 0.
//  - Sub mode: b_eff = ~b, c0 = ~cin. Add mode: b_eff = b, c0 = cin.
//  - Stage k (0..STAGES-1) adds slice k of a and b_eff plus the carry registered
//    by stage k-1 (stage 0 uses c0). It registers the slice sum and carry-out.
//    Upper slices travel unmodified with their transaction.
//  - Global enable: en = ~out_valid | out_ready. When en=0, every stage holds
//    and in_ready = 0. When en=1, all stages shift by one. in_ready = en.
//  - Transfer in: in_valid & in_ready. A bubble (in_valid=0 while en=1) enters
//    as valid=0. Bubbles are not compacted.
//  - Latency: exactly STAGES cycles from accept to out_valid with no stall.
//    Throughput: 1 per cycle.
//  - Result: cout = carry out of the last slice.
//    ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]), using registered
//    operand MSBs. zero = ~|sum.
//  - Output holds stable while out_valid & ~out_ready (AXI-style; no drop, no
//    duplicate).
//  - Simultaneous in accept and out accept in the same cycle: both occur and the
//    pipe shifts.
//  - sub, cin, and operands are captured per transaction; changing them
//    mid-flight does not affect in-flight results.
//  - Reset mid-operation discards all in-flight transactions. No partial results
//    appear.
//  - STAGES=1 degenerates to a single registered adder with latency 1.
//  - Parameter violation (WIDTH % STAGES != 0) triggers $error at elaboration.
// TESTING (WIDTH=8, STAGES=4 unless stated)
//  1. Add: a=200, b=100, cin=0, sub=0 -> after 4 clk: sum=44, cout=1, ovf=0,
//     zero=0.
//  2. Signed overflow: a=0x64, b=0x64 -> sum=0xC8, ovf=1, cout=0.
//     Then a=0xFF, b=0x01 -> sum=0, cout=1, zero=1, ovf=0.
//  3. Sub: a=5, b=7, sub=1, cin=0 -> sum=0xFE, cout=0, ovf=0.
//     a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
//     a=9, b=3, sub=1, cin=1 -> sum=5.
//  4. Streaming: 16 back-to-back random ops with out_ready=1 -> 16 results on
//     consecutive cycles, in order, matching the reference model.
//  5. Backpressure: out_ready=0 for 6 cycles mid-stream -> in_ready=0 once
//     out_valid=1, outputs stable. Release -> no loss or duplication, order kept.
//  6. Reset while 3 ops are in flight: assert rst between edges -> out_valid=0 and
//     sum=0 immediately, no stale output after release. Repeat tests 1 and 3 with
//     STAGES=1 and WIDTH=32/STAGES=8.

Source files
------------

// File: rtl/pipe_addsub_n.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES slices,
// one register rank per slice, with valid/ready flow control on both ends.
module pipe_addsub_n #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int WS = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_addsub_n: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high. The whole pipe advances together (en); a stalled output stalls input.
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k sees only operand bits from slice k upward; lower slices are done.
    localparam int AW = WIDTH - k * WS;

    logic [AW-1:0]         a_src;
    logic [AW-1:0]         b_src;
    logic                  c_src;
    logic                  v_src;
    logic                  am_src;
    logic                  bm_src;
    logic [(k+1)*WS-1:0]   s_next;
    logic [WS:0]           slice;

    logic                  v_q;
    logic                  c_q;
    logic                  am_q;
    logic                  bm_q;
    logic [(k+1)*WS-1:0]   s_q;

    assign slice = {1'b0, a_src[WS-1:0]} + {1'b0, b_src[WS-1:0]} + {{WS{1'b0}}, c_src};

    if (k == 0) begin : g_first
      assign a_src  = a;
      assign b_src  = b_eff;
      assign c_src  = c0;
      assign v_src  = in_valid;
      assign am_src = a[WIDTH-1];
      assign bm_src = b_eff[WIDTH-1];
      assign s_next = slice[WS-1:0];
    end else begin : g_next
      assign a_src  = g_stage[k-1].g_fwd.a_q;
      assign b_src  = g_stage[k-1].g_fwd.b_q;
      assign c_src  = g_stage[k-1].c_q;
      assign v_src  = g_stage[k-1].v_q;
      assign am_src = g_stage[k-1].am_q;
      assign bm_src = g_stage[k-1].bm_q;
      assign s_next = {slice[WS-1:0], g_stage[k-1].s_q};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        am_q <= 1'b0;
        bm_q <= 1'b0;
        s_q  <= '0;
      end else if (en) begin
        v_q  <= v_src;
        c_q  <= slice[WS];
        am_q <= am_src;
        bm_q <= bm_src;
        s_q  <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [AW-WS-1:0] a_q;
      logic [AW-WS-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_src[AW-1:WS];
          b_q <= b_src[AW-1:WS];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = (g_stage[STAGES-1].am_q == g_stage[STAGES-1].bm_q) &
                     (sum[WIDTH-1] != g_stage[STAGES-1].am_q);
  assign zero      = ~|sum;

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;

endmodule
